// File: rtl/nbit_four_req_rr_arbiter_pkg.sv
// Shared constants, state type and round-robin pick helper for the
// four-requester arbiter.
package nbit_four_req_rr_arbiter_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } arb_state_t;

  // Returns {found, index}: first set bit of req searching last_ptr+1 .. last_ptr+4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last_ptr);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last_ptr + 2'(k);
      if (req[idx] && !r[2]) begin
        r = {1'b1, idx};
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/nbit_four_req_rr_arbiter_mux.sv
// N-bit 4:1 datapath mux shared by the four requesters.
module N_bit_four_to_one_mux
  import nbit_four_req_rr_arbiter_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  logic [1:0]   sel,
  output logic [N-1:0] out
);

  always_comb begin
    out = a;
    case (sel)
      REQ_A:   out = a;
      REQ_B:   out = b;
      REQ_C:   out = c;
      REQ_D:   out = d;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/nbit_four_req_rr_arbiter.sv
// Round-robin arbiter sharing one N-bit 4:1 mux among four requesters,
// forwarding the winner over valid/ready and counting completed transfers.
//
//   state | meaning
//   IDLE  | no grant outstanding, out_valid=0, gnt=0, sel holds last value
//   GRANT | one requester granted, out_valid=1, held until out_ready
module nbit_four_req_rr_arbiter
  import nbit_four_req_rr_arbiter_pkg::*;
#(
  parameter int N     = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [CNT_W-1:0] xfer_count
);

  arb_state_t state;
  logic [1:0] last_ptr;
  logic       hs;
  logic [3:0] req_eff;
  logic [1:0] ptr_eff;
  logic [2:0] pick;

  N_bit_four_to_one_mux #(.N(N)) u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .out (out_data)
  );

  assign hs  = out_valid & out_ready;
  assign ack = gnt & {4{hs}};

  // On a handshake the current grantee is masked and the search starts
  // after it, so the next winner is known in the same cycle (no bubble).
  always_comb begin
    req_eff = req;
    ptr_eff = last_ptr;
    if (hs) begin
      req_eff = req & ~gnt;
      ptr_eff = sel;
    end
    pick = rr_pick(req_eff, ptr_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      gnt        <= 4'b0000;
      sel        <= 2'b00;
      last_ptr   <= 2'd3;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick[2]) begin
            state     <= GRANT;
            out_valid <= 1'b1;
            gnt       <= onehot4(pick[1:0]);
            sel       <= pick[1:0];
          end
        end
        GRANT: begin
          if (out_ready) begin
            xfer_count <= xfer_count + {{(CNT_W-1){1'b0}}, 1'b1};
            last_ptr   <= sel;
            if (pick[2]) begin
              gnt <= onehot4(pick[1:0]);
              sel <= pick[1:0];
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              gnt       <= 4'b0000;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          gnt       <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_four_req_rr_arbiter.sv
// Directed self-checking bench for the round-robin arbiter; a second
// instance with a 2-bit counter covers the transfer-count wrap.
module tb_nbit_four_req_rr_arbiter;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [N-1:0] a, b, c, d;
  logic         out_ready;
  logic         out_valid, out_valid2;
  logic [N-1:0] out_data, out_data2;
  logic [1:0]   sel, sel2;
  logic [3:0]   gnt, gnt2;
  logic [3:0]   ack, ack2;
  logic [7:0]   xfer_count;
  logic [1:0]   xfer_count2;

  int n_checks = 0;
  int n_errors = 0;

  nbit_four_req_rr_arbiter #(.N(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .gnt(gnt), .ack(ack), .xfer_count(xfer_count)
  );

  nbit_four_req_rr_arbiter #(.N(N), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .out_valid(out_valid2), .out_data(out_data2),
    .sel(sel2), .gnt(gnt2), .ack(ack2), .xfer_count(xfer_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
    chk("gnt_iff_valid", 32'((gnt != 4'b0) == out_valid), 32'd1);
    chk("gnt2_iff_valid", 32'((gnt2 != 4'b0) == out_valid2), 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [N-1:0] words [4];
  logic [1:0]   wrap_exp [5];

  initial begin
    words[0] = 5'b01010; words[1] = 5'b10101; words[2] = 5'b11011; words[3] = 5'b11100;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    rst = 1'b1; req = 4'b0; out_ready = 1'b0;
    a = words[0]; b = words[1]; c = words[2]; d = words[3];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_sel",   32'(sel), 32'd0);
    chk("rst_count", 32'(xfer_count), 32'd0);
    chk("rst_ack",   32'(ack), 32'h0);

    // Single request from b
    req = 4'b0010; out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_sel",   32'(sel), 32'd1);
    chk("single_gnt",   32'(gnt), 32'b0010);
    chk("single_data",  32'(out_data), 32'b10101);
    chk("single_ack",   32'(ack), 32'b0010);
    tick(); req = 4'b0;
    @(negedge clk);
    chk("single_count", 32'(xfer_count), 32'd1);
    chk("single_idle",  32'(out_valid), 32'd0);

    // All four, back to back
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("all4_valid", 32'(out_valid), 32'd1);
      chk("all4_sel",   32'(sel), 32'(i));
      chk("all4_gnt",   32'(gnt), 32'(4'b0001 << i));
      chk("all4_data",  32'(out_data), 32'(words[i]));
      chk("all4_ack",   32'(ack), 32'(4'b0001 << i));
      tick(); req[i] = 1'b0;
    end
    @(negedge clk);
    chk("all4_idle",  32'(out_valid), 32'd0);
    chk("all4_count", 32'(xfer_count), 32'd4);

    // Backpressure on c
    req = 4'b0100; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sel",   32'(sel), 32'd2);
      chk("bp_data",  32'(out_data), 32'b11011);
      chk("bp_ack",   32'(ack), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ack_rdy", 32'(ack), 32'b0100);
    tick(); req = 4'b0;
    @(negedge clk);
    chk("bp_count", 32'(xfer_count), 32'd5);

    // Fairness: req[0] held, req[3] rises during a's grant -> 0,3,0
    req = 4'b0001;
    tick(); req[3] = 1'b1;
    @(negedge clk);
    chk("fair_sel0", 32'(sel), 32'd0);
    chk("fair_ack0", 32'(ack), 32'b0001);
    tick();
    @(negedge clk);
    chk("fair_sel3", 32'(sel), 32'd3);
    chk("fair_ack3", 32'(ack), 32'b1000);
    tick(); req[3] = 1'b0;
    @(negedge clk);
    chk("fair_sel0b", 32'(sel), 32'd0);
    chk("fair_gnt0b", 32'(gnt), 32'b0001);
    tick(); req = 4'b0;
    @(negedge clk);
    chk("fair_idle",  32'(out_valid), 32'd0);
    chk("fair_count", 32'(xfer_count), 32'd8);

    // Reset mid-grant with out_ready low
    req = 4'b0010; out_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_ack",   32'(ack), 32'h0);
    rst = 1'b1;
    tick(); rst = 1'b0; req = 4'b1001; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_gnt",   32'(gnt), 32'h0);
    chk("mid_rst_sel",   32'(sel), 32'd0);
    chk("mid_rst_count", 32'(xfer_count), 32'd0);
    chk("mid_rst_ack",   32'(ack), 32'h0);
    tick();
    @(negedge clk);
    chk("mid_prio_sel", 32'(sel), 32'd0);
    chk("mid_prio_gnt", 32'(gnt), 32'b0001);
    tick(); req = 4'b1000;
    @(negedge clk);
    chk("mid_next_sel", 32'(sel), 32'd3);
    tick(); req = 4'b0;

    // Counter wrap: 5 single transfers from a
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      req = 4'b0001;
      tick();
      @(negedge clk);
      chk("wrap_ack", 32'(ack2), 32'b0001);
      tick(); req = 4'b0;
      @(negedge clk);
      chk("wrap_count2", 32'(xfer_count2), 32'(wrap_exp[t]));
      chk("wrap_count8", 32'(xfer_count), 32'(t + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
